// File: rtl/sp_ram_ctrl.sv
// Single-port RAM with a valid/ready request port and per-byte write enables.
// Two-stage pipeline (request register, then array access); optional init sweep after reset.
module sp_ram_ctrl #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned BYTE_WIDTH    = 8,
  parameter int unsigned RAM_DEPTH     = 256,
  parameter int unsigned RDW_MODE      = 0,
  parameter int unsigned INIT_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
  localparam int unsigned NUM_BYTES    = DATA_WIDTH / BYTE_WIDTH,
  localparam int unsigned LB_RAM_DEPTH = $clog2(RAM_DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_wr,
  input  logic [LB_RAM_DEPTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [NUM_BYTES-1:0]    req_be,
  output logic                    rd_valid,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    init_done
);

  localparam int unsigned AW1 = LB_RAM_DEPTH + 1;

  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
    $error("sp_ram_ctrl: DATA_WIDTH must be a multiple of BYTE_WIDTH");
  end

  logic [DATA_WIDTH-1:0]   mem [RAM_DEPTH];

  logic [0:0]              state, state_nxt;
  logic [LB_RAM_DEPTH-1:0] init_addr, init_addr_nxt;
  logic                    ready_nxt, done_nxt;

  logic                    s1_valid, s1_wr;
  logic [LB_RAM_DEPTH-1:0] s1_addr;
  logic [DATA_WIDTH-1:0]   s1_wdata;
  logic [NUM_BYTES-1:0]    s1_be;

  logic                    accept;
  logic                    in_range;
  logic [DATA_WIDTH-1:0]   old_word, merged_word;

  assign accept   = req_valid & req_ready;
  assign in_range = ({1'b0, s1_addr} < AW1'(RAM_DEPTH));

  // FSM state and registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= (INIT_ON_RESET != 0) ? ST_INIT : ST_READY;
      init_addr <= '0;
      req_ready <= 1'b0;
      init_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      init_addr <= init_addr_nxt;
      req_ready <= ready_nxt;
      init_done <= done_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    init_addr_nxt = init_addr;
    ready_nxt     = 1'b0;
    done_nxt      = 1'b0;
    case (state)
      ST_INIT: begin
        init_addr_nxt = init_addr + LB_RAM_DEPTH'(1);
        if (init_addr == LB_RAM_DEPTH'(RAM_DEPTH - 1)) begin
          state_nxt = ST_READY;
          ready_nxt = 1'b1;
          done_nxt  = 1'b1;
        end
      end
      ST_READY: begin
        ready_nxt = 1'b1;
        done_nxt  = 1'b1;
      end
      default: state_nxt = ST_INIT;
    endcase
  end

  // Stage 1: request capture
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= accept;
    end
    if (accept) begin
      s1_wr    <= req_wr;
      s1_addr  <= req_addr;
      s1_wdata <= req_wdata;
      s1_be    <= req_be;
    end
  end

  // Byte-lane merge of the stage-1 write over the current word
  always_comb begin
    old_word = '0;
    if (in_range) old_word = mem[s1_addr];
    merged_word = old_word;
    for (int unsigned i = 0; i < NUM_BYTES; i++) begin
      if (s1_be[i]) merged_word[i*BYTE_WIDTH +: BYTE_WIDTH] = s1_wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end

  // Array write port: sweep or stage-1 write, both suppressed by rst
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == ST_INIT) begin
        mem[init_addr] <= INIT_VALUE;
      end else if (s1_valid && s1_wr && in_range) begin
        mem[s1_addr] <= merged_word;
      end
    end
  end

  // Stage 2: read return register
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= 1'b0;
      if (s1_valid) begin
        if (!s1_wr) begin
          rd_valid <= 1'b1;
          rd_data  <= old_word;
        end else if (RDW_MODE == 1) begin
          rd_valid <= 1'b1;
          rd_data  <= old_word;
        end else if (RDW_MODE == 2) begin
          rd_valid <= 1'b1;
          rd_data  <= in_range ? merged_word : '0;
        end
      end
    end
  end

endmodule
